// File: rtl/writeback_unit.sv
// Writeback arbiter: merges in-order load responses and ALU results into one
// registered register-bank write port, tracking pending load destinations for hazards.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     alu_link_valid,
  input  logic [31:0]              alu_link_data,
  output logic                     alu_ready,
  input  logic                     ld_issue_valid,
  input  logic [4:0]               ld_issue_rd,
  output logic                     ld_issue_ready,
  input  logic                     ld_resp_valid,
  input  logic [31:0]              ld_resp_data,
  input  logic [4:0]               rh_addr,
  input  logic [4:0]               ro_addr,
  output logic                     stall,
  output logic [4:0]               RdAddress,
  output logic [31:0]              WriteData,
  output logic                     write_condition,
  output logic [1:0]               TypeCode,
  output logic                     Load,
  output logic                     should_store_link,
  output logic [31:0]              new_LinkValue,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
  localparam logic [1:0] TYPE_ALU  = 2'b00;
  localparam logic [1:0] TYPE_LOAD = 2'b01;

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // ready never depends on valid. A load response has no ready and is always consumed.
  logic [4:0]       pendRd [DEPTH];
  logic [DEPTH-1:0] pendValid;
  logic [PW-1:0]    wrPtr, rdPtr;
  logic             armed;
  logic             push, pop, aluAccept;
  logic             wawHit, hazardRh, hazardRo;

  always_comb begin
    wawHit   = 1'b0;
    hazardRh = 1'b0;
    hazardRo = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pendValid[i]) begin
        if (pendRd[i] == alu_rd)  wawHit   = 1'b1;
        if (pendRd[i] == rh_addr) hazardRh = 1'b1;
        if (pendRd[i] == ro_addr) hazardRo = 1'b1;
      end
    end
  end

  // armed blocks ALU writes on the first edge after reset release
  assign ld_issue_ready = (count < FULL);
  assign alu_ready      = armed && !ld_resp_valid && !wawHit;
  assign push           = ld_issue_valid && ld_issue_ready;
  assign pop            = ld_resp_valid && (count != '0);
  assign aluAccept      = alu_valid && alu_ready;
  assign stall          = hazardRh || hazardRo ||
                          (write_condition && ((RdAddress == rh_addr) || (RdAddress == ro_addr)));

  always_ff @(posedge clock) begin
    if (push) pendRd[wrPtr] <= ld_issue_rd;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pendValid <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      armed     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (push) begin
        pendValid[wrPtr] <= 1'b1;
        wrPtr            <= wrPtr + 1'b1;
      end
      if (pop) begin
        pendValid[rdPtr] <= 1'b0;
        rdPtr            <= rdPtr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ld_resp_valid && (count == '0)) err_underflow <= 1'b1;
    end
  end

  // Bank-side outputs: address/data/type hold between writes, strobes return to 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RdAddress         <= '0;
      WriteData         <= '0;
      write_condition   <= 1'b0;
      TypeCode          <= TYPE_ALU;
      Load              <= 1'b0;
      should_store_link <= 1'b0;
      new_LinkValue     <= '0;
    end else if (pop) begin
      RdAddress         <= pendRd[rdPtr];
      WriteData         <= ld_resp_data;
      write_condition   <= 1'b1;
      TypeCode          <= TYPE_LOAD;
      Load              <= 1'b1;
      should_store_link <= 1'b0;
    end else if (aluAccept) begin
      RdAddress         <= alu_rd;
      WriteData         <= alu_data;
      write_condition   <= 1'b1;
      TypeCode          <= TYPE_ALU;
      Load              <= 1'b0;
      should_store_link <= alu_link_valid;
      if (alu_link_valid) new_LinkValue <= alu_link_data;
    end else begin
      write_condition   <= 1'b0;
      Load              <= 1'b0;
      should_store_link <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a reference model predicts each bank write
// into exp_q at drive time; writes are popped and compared one cycle later.
module tb_writeback_unit;

  localparam int DEPTH = 4;
  localparam int W = 39;  // {rd[4:0], data[31:0], type[1:0]}

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid, alu_link_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data, alu_link_data;
  logic        ld_issue_valid, ld_issue_ready, ld_resp_valid;
  logic [4:0]  ld_issue_rd, rh_addr, ro_addr;
  logic [31:0] ld_resp_data;
  logic        stall, write_condition, Load, should_store_link, err_underflow;
  logic [4:0]  RdAddress;
  logic [31:0] WriteData, new_LinkValue;
  logic [1:0]  TypeCode;
  logic [$clog2(DEPTH):0] count;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_link_valid(alu_link_valid), .alu_link_data(alu_link_data), .alu_ready(alu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .rh_addr(rh_addr), .ro_addr(ro_addr), .stall(stall),
    .RdAddress(RdAddress), .WriteData(WriteData), .write_condition(write_condition),
    .TypeCode(TypeCode), .Load(Load), .should_store_link(should_store_link),
    .new_LinkValue(new_LinkValue), .count(count), .err_underflow(err_underflow)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  logic [4:0]   pend_q[$];
  int           tests = 0;
  int           failed = 0;
  bit           armed, exp_err, exp_link_wr, last_wc;
  logic [31:0]  exp_link;
  logic [4:0]   last_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_pend(input logic [4:0] a);
    foreach (pend_q[i]) if (pend_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0; alu_link_valid = 0; alu_link_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_resp_valid = 0; ld_resp_data = 0;
    rh_addr = 0; ro_addr = 0;
  endtask

  task automatic model_reset();
    exp_q.delete(); pend_q.delete();
    armed = 0; exp_err = 0; exp_link = 0; exp_link_wr = 0; last_wc = 0; last_rd = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wc"},    write_condition, 0);
    check({tag, "_rd"},    RdAddress, 0);
    check({tag, "_data"},  WriteData, 0);
    check({tag, "_type"},  TypeCode, 0);
    check({tag, "_load"},  Load, 0);
    check({tag, "_sls"},   should_store_link, 0);
    check({tag, "_link"},  new_LinkValue, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_err"},   err_underflow, 0);
  endtask

  // driver: inputs already set; predict, clock once, then compare
  task automatic drive_cycle(input string tag);
    int sz;
    bit m_ready, wr;
    logic [W-1:0] e;
    #1;
    sz = pend_q.size();
    m_ready = armed && !ld_resp_valid && !in_pend(alu_rd);
    check({tag, "_alu_ready"}, alu_ready, m_ready);
    check({tag, "_issue_ready"}, ld_issue_ready, sz < DEPTH);
    check({tag, "_stall"}, stall, in_pend(rh_addr) || in_pend(ro_addr) ||
          (last_wc && (last_rd == rh_addr || last_rd == ro_addr)));
    wr = 0;
    if (ld_resp_valid && sz > 0) begin
      exp_q.push_back({pend_q.pop_front(), ld_resp_data, 2'b01});
      wr = 1; exp_link_wr = 0;
    end else if (alu_valid && m_ready) begin
      exp_q.push_back({alu_rd, alu_data, 2'b00});
      wr = 1; exp_link_wr = alu_link_valid;
      if (alu_link_valid) exp_link = alu_link_data;
    end
    if (ld_resp_valid && sz == 0) exp_err = 1;
    if (ld_issue_valid && sz < DEPTH) pend_q.push_back(ld_issue_rd);
    @(posedge clock);
    #1;
    armed = 1;
    check({tag, "_wc"}, write_condition, wr);
    if (write_condition && exp_q.size() == 0) check({tag, "_unexpected_write"}, 1, 0);
    if (wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rd"}, RdAddress, e[38:34]);
      check({tag, "_data"}, WriteData, e[33:2]);
      check({tag, "_type"}, TypeCode, e[1:0]);
      check({tag, "_load"}, Load, e[1:0] == 2'b01);
      check({tag, "_sls"}, should_store_link, exp_link_wr);
      last_rd = e[38:34];
    end else begin
      check({tag, "_load_idle"}, Load, 0);
      check({tag, "_sls_idle"}, should_store_link, 0);
    end
    last_wc = wr;
    check({tag, "_link"}, new_LinkValue, exp_link);
    check({tag, "_count"}, count, pend_q.size());
    check({tag, "_err"}, err_underflow, exp_err);
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 0;
    #3;
    check_reset_outputs("reset");
    @(posedge clock); #1;
    reset_n = 1;
    drive_cycle("settle");

    // single ALU write, then idle
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    drive_cycle("alu5");
    idle();
    drive_cycle("alu5_after");

    // two loads in order
    ld_issue_valid = 1; ld_issue_rd = 3;  drive_cycle("iss3");
    ld_issue_rd = 7;                      drive_cycle("iss7");
    idle(); ld_resp_valid = 1; ld_resp_data = 32'hAA; drive_cycle("respAA");
    ld_resp_data = 32'hBB;                drive_cycle("respBB");
    idle();                               drive_cycle("idle1");

    // fill, then refused issue alongside a response
    ld_issue_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_issue_rd = 5'(10 + i);
      drive_cycle("fill");
    end
    ld_issue_rd = 14; ld_resp_valid = 1; ld_resp_data = 32'h55;
    drive_cycle("full_push_pop");
    ld_issue_valid = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      ld_resp_data = $urandom;
      drive_cycle("drain");
    end
    idle(); drive_cycle("idle2");

    // WAW block and read hazard on rd 9
    ld_issue_valid = 1; ld_issue_rd = 9; drive_cycle("iss9");
    idle(); alu_valid = 1; alu_rd = 9; alu_data = 32'h99; rh_addr = 9;
    drive_cycle("waw_block1");
    drive_cycle("waw_block2");
    ld_resp_valid = 1; ld_resp_data = 32'h909;
    drive_cycle("resp9");
    ld_resp_valid = 0;
    drive_cycle("alu9_accept");
    idle(); drive_cycle("idle3");

    // response beats ALU, then underflow
    ld_issue_valid = 1; ld_issue_rd = 20; drive_cycle("iss20");
    idle(); ld_resp_valid = 1; ld_resp_data = 32'hCC;
    alu_valid = 1; alu_rd = 21; alu_data = 32'hDD;
    drive_cycle("resp_beats_alu");
    ld_resp_valid = 0;
    drive_cycle("alu21");
    idle(); ld_resp_valid = 1; ld_resp_data = 32'hEE;
    drive_cycle("underflow");
    idle(); drive_cycle("err_sticky");

    // link register update, then random ALU traffic
    alu_valid = 1; alu_rd = 1; alu_data = 32'h7; alu_link_valid = 1; alu_link_data = 32'h40;
    drive_cycle("link");
    idle(); drive_cycle("link_hold");
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      alu_link_valid = 1'($urandom_range(0, 1)); alu_link_data = $urandom;
      ro_addr = 5'($urandom_range(0, 31));
      drive_cycle("rand_alu");
    end
    idle(); drive_cycle("idle4");

    // reset mid-queue with a write in flight
    ld_issue_valid = 1; ld_issue_rd = 2; drive_cycle("iss2");
    ld_issue_rd = 4; alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    drive_cycle("iss4_alu6");
    idle();
    reset_n = 0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    #1;
    reset_n = 1;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h660;
    drive_cycle("post_reset_blocked");
    drive_cycle("post_reset_accept");
    idle(); drive_cycle("idle5");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
